// File: rtl/hazard_stall_ctrl.sv
// Hazard detection and stall control for the 5-stage MIPS pipeline.
// Covers load-use, branch-operand and MDU hazards, sequences the MDU, and counts stall cycles.
module hazard_stall_ctrl #(
  parameter int unsigned MDU_LAT = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             CE,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             rs_used,
  input  logic             rt_used,
  input  logic             id_branch,
  input  logic             id_hilo_rd,
  input  logic             id_mdu_start,
  input  logic             branch_taken,
  input  logic [4:0]       ex_wreg,
  input  logic             ex_we,
  input  logic             ex_memread,
  input  logic [4:0]       mem_wreg,
  input  logic             mem_memread,
  output logic             PC_shouldstall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             mdu_busy,
  output logic             mdu_go,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic {StIdle, StBusy} state_e;

  localparam logic [3:0] MduLat = 4'(MDU_LAT);
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           r_state, w_state_d;
  logic [3:0]       r_cnt, w_cnt_d;
  logic [CNT_W-1:0] r_stall_count, w_stall_count_d;

  logic w_match_ex, w_match_mem;
  logic w_load_use, w_br_dep, w_mdu_hz, w_stall, w_mdu_go;

  assign w_match_ex  = ex_we & (ex_wreg != 5'd0) &
                       ((rs_used & (rs_id == ex_wreg)) | (rt_used & (rt_id == ex_wreg)));
  assign w_match_mem = mem_memread & (mem_wreg != 5'd0) &
                       ((rs_used & (rs_id == mem_wreg)) | (rt_used & (rt_id == mem_wreg)));

  assign w_load_use = ex_memread & w_match_ex;
  assign w_br_dep   = id_branch & (w_match_ex | w_match_mem);
  // A new start is allowed in the final busy cycle (cnt==1) so back-to-back ops never bubble;
  // hi/lo reads must wait until the result is complete.
  assign w_mdu_hz   = (id_hilo_rd & (r_state == StBusy)) | (id_mdu_start & (r_cnt > 4'd1));
  assign w_stall    = w_load_use | w_br_dep | w_mdu_hz;
  assign w_mdu_go   = id_mdu_start & ~w_stall & CE;

  assign PC_shouldstall = w_stall;
  assign ifid_stall     = w_stall;
  assign idex_flush     = w_stall;
  assign ifid_flush     = branch_taken & ~w_stall;
  assign mdu_busy       = (r_state == StBusy);
  assign mdu_go         = w_mdu_go;
  assign stall_count    = r_stall_count;

  always_comb begin
    w_state_d       = r_state;
    w_cnt_d         = r_cnt;
    w_stall_count_d = r_stall_count;

    if (w_mdu_go) begin
      w_cnt_d = MduLat;
    end else if (CE && (r_cnt != 4'd0)) begin
      w_cnt_d = r_cnt - 4'd1;
    end

    unique case (r_state)
      StIdle: if (w_mdu_go) w_state_d = StBusy;
      StBusy: if (!w_mdu_go && CE && (r_cnt == 4'd1)) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase

    if (CE && w_stall) begin
      w_stall_count_d = r_stall_count + CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StIdle;
      r_cnt         <= 4'd0;
      r_stall_count <= '0;
    end else begin
      r_state       <= w_state_d;
      r_cnt         <= w_cnt_d;
      r_stall_count <= w_stall_count_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus randomized traffic
// compared against an integer-level reference model.
module tb_hazard_stall_ctrl;

  localparam int unsigned LAT = 4;

  logic        clk = 1'b0;
  logic        rst, CE;
  logic [4:0]  rs_id, rt_id, ex_wreg, mem_wreg;
  logic        rs_used, rt_used, id_branch, id_hilo_rd, id_mdu_start, branch_taken;
  logic        ex_we, ex_memread, mem_memread;
  logic        PC_shouldstall, ifid_stall, ifid_flush, idex_flush, mdu_busy, mdu_go;
  logic [31:0] stall_count;

  int checks = 0;
  int errors = 0;

  // Reference model state: busy cycles remaining and total stall cycles.
  int          m_rem = 0;
  logic [31:0] m_cnt = '0;

  logic [5:0]  obs;

  hazard_stall_ctrl #(.MDU_LAT(LAT), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .CE(CE),
    .rs_id(rs_id), .rt_id(rt_id), .rs_used(rs_used), .rt_used(rt_used),
    .id_branch(id_branch), .id_hilo_rd(id_hilo_rd), .id_mdu_start(id_mdu_start),
    .branch_taken(branch_taken),
    .ex_wreg(ex_wreg), .ex_we(ex_we), .ex_memread(ex_memread),
    .mem_wreg(mem_wreg), .mem_memread(mem_memread),
    .PC_shouldstall(PC_shouldstall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .mdu_busy(mdu_busy), .mdu_go(mdu_go),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic bit reads(input logic [4:0] r);
    return (r != 5'd0) && ((rs_used && rs_id == r) || (rt_used && rt_id == r));
  endfunction

  function automatic bit exp_stall();
    bit mex, mmem;
    mex  = ex_we && reads(ex_wreg);
    mmem = mem_memread && reads(mem_wreg);
    return (ex_memread && mex) || (id_branch && (mex || mmem)) ||
           (id_hilo_rd && m_rem > 0) || (id_mdu_start && m_rem > 1);
  endfunction

  function automatic bit exp_go();
    return id_mdu_start && !exp_stall() && CE;
  endfunction

  function automatic logic [5:0] exp_outs();
    bit s;
    s = exp_stall();
    return {s, s, branch_taken && !s, s, m_rem > 0, exp_go()};
  endfunction

  task automatic clear_inputs();
    CE = 1'b1; rs_id = '0; rt_id = '0; rs_used = 0; rt_used = 0;
    id_branch = 0; id_hilo_rd = 0; id_mdu_start = 0; branch_taken = 0;
    ex_wreg = '0; ex_we = 0; ex_memread = 0; mem_wreg = '0; mem_memread = 0;
  endtask

  // Advance one clock edge and step the model with the inputs seen at that edge.
  task automatic tick();
    bit s, g;
    @(posedge clk);
    s = exp_stall();
    g = exp_go();
    if (rst) begin
      m_rem = 0;
      m_cnt = '0;
    end else begin
      if (CE && s) m_cnt = m_cnt + 1;
      if (g) m_rem = LAT;
      else if (CE && m_rem > 0) m_rem = m_rem - 1;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    do_reset();
    #1;
    obs = {PC_shouldstall, ifid_stall, ifid_flush, idex_flush, mdu_busy, mdu_go};
    checks++;
    if (obs !== 6'b0) begin
      errors++; $display("FAIL reset_outs got=%b want=%b", obs, 6'b0);
    end
    checks++;
    if (stall_count !== 32'd0) begin
      errors++; $display("FAIL reset_count got=%0d want=0", stall_count);
    end
  endtask

  task automatic test_load_use();
    logic [31:0] start;
    clear_inputs();
    start = m_cnt;
    ex_memread = 1; ex_we = 1; ex_wreg = 5'd8; rs_id = 5'd8; rs_used = 1;
    #1;
    obs = {PC_shouldstall, ifid_stall, ifid_flush, idex_flush, mdu_busy, mdu_go};
    checks++;
    if (obs !== 6'b110100) begin
      errors++; $display("FAIL load_use_stall got=%b want=%b", obs, 6'b110100);
    end
    tick();
    clear_inputs();
    ex_memread = 1; ex_we = 1; ex_wreg = 5'd0; rs_id = 5'd0; rs_used = 1;
    #1;
    checks++;
    if (stall_count !== start + 32'd1) begin
      errors++; $display("FAIL load_use_count got=%0d want=%0d", stall_count, start + 1);
    end
    checks++;
    if (PC_shouldstall !== 1'b0) begin
      errors++; $display("FAIL load_use_zero_reg got=%b want=0", PC_shouldstall);
    end
    tick();
  endtask

  task automatic test_branch_after_load();
    clear_inputs();
    do_reset();
    id_branch = 1; rs_id = 5'd9; rs_used = 1; branch_taken = 1;
    for (int c = 1; c <= 3; c++) begin
      ex_memread = (c == 1); ex_we = (c == 1); ex_wreg = (c == 1) ? 5'd9 : 5'd0;
      mem_memread = (c == 2); mem_wreg = (c == 2) ? 5'd9 : 5'd0;
      #1;
      checks++;
      if ({PC_shouldstall, ifid_flush} !== ((c < 3) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL branch_load c%0d stall/flush got=%b%b want=%b", c, PC_shouldstall,
                 ifid_flush, (c < 3) ? 2'b10 : 2'b01);
      end
      if (c == 3) begin
        checks++;
        if (stall_count !== 32'd2) begin
          errors++; $display("FAIL branch_load_count got=%0d want=2", stall_count);
        end
      end
      tick();
    end
  endtask

  task automatic test_mdu();
    clear_inputs();
    do_reset();
    id_mdu_start = 1;
    #1;
    checks++;
    if (mdu_go !== 1'b1 || mdu_busy !== 1'b0) begin
      errors++; $display("FAIL mdu_start go=%b busy=%b want go=1 busy=0", mdu_go, mdu_busy);
    end
    tick();
    clear_inputs();
    for (int k = 1; k <= 5; k++) begin
      id_hilo_rd = (k >= 2);
      #1;
      obs = {PC_shouldstall, ifid_stall, ifid_flush, idex_flush, mdu_busy, mdu_go};
      checks++;
      if (obs !== {{2{k >= 2 && k <= 4}}, 1'b0, k >= 2 && k <= 4, k <= 4, 1'b0}) begin
        errors++; $display("FAIL mdu_busy_k%0d got=%b", k, obs);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    do_reset();
    id_mdu_start = 1;
    tick();
    clear_inputs();
    repeat (3) tick();
    id_mdu_start = 1;
    #1;
    checks++;
    if ({PC_shouldstall, mdu_go, mdu_busy} !== 3'b011) begin
      errors++;
      $display("FAIL b2b_restart stall/go/busy got=%b%b%b want=011", PC_shouldstall, mdu_go,
               mdu_busy);
    end
    tick();
    clear_inputs();
    for (int k = 1; k <= 5; k++) begin
      #1;
      checks++;
      if (mdu_busy !== (k <= 4)) begin
        errors++; $display("FAIL b2b_busy_k%0d got=%b want=%b", k, mdu_busy, k <= 4);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_op();
    clear_inputs();
    do_reset();
    id_mdu_start = 1;
    tick();
    clear_inputs();
    repeat (2) tick();
    id_hilo_rd = 1;
    rst = 1;
    #1;
    checks++;
    if (PC_shouldstall !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pre got=%b want=1", PC_shouldstall);
    end
    tick();
    rst = 0;
    #1;
    checks++;
    if ({mdu_busy, PC_shouldstall} !== 2'b00 || stall_count !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid_post busy=%b stall=%b count=%0d want 0/0/0", mdu_busy,
               PC_shouldstall, stall_count);
    end
    tick();
  endtask

  task automatic test_ce_freeze();
    logic [31:0] start;
    clear_inputs();
    do_reset();
    id_mdu_start = 1;
    tick();
    clear_inputs();
    tick();
    start = m_cnt;
    CE = 0; ex_memread = 1; ex_we = 1; ex_wreg = 5'd3; rt_id = 5'd3; rt_used = 1;
    repeat (3) begin
      #1;
      checks++;
      if ({PC_shouldstall, mdu_busy} !== 2'b11 || stall_count !== start) begin
        errors++;
        $display("FAIL ce_freeze stall=%b busy=%b count=%0d want 1/1/%0d", PC_shouldstall,
                 mdu_busy, stall_count, start);
      end
      tick();
    end
    clear_inputs();
    for (int k = 1; k <= 4; k++) begin
      #1;
      checks++;
      if (mdu_busy !== (k <= 3)) begin
        errors++; $display("FAIL ce_resume_k%0d got=%b want=%b", k, mdu_busy, k <= 3);
      end
      tick();
    end
  endtask

  task automatic test_random();
    clear_inputs();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      CE = ($urandom_range(0, 9) != 0);
      rs_id = 5'($urandom_range(0, 3)); rt_id = 5'($urandom_range(0, 3));
      rs_used = 1'($urandom); rt_used = 1'($urandom);
      id_branch = ($urandom_range(0, 3) == 0); branch_taken = 1'($urandom);
      id_hilo_rd = ($urandom_range(0, 4) == 0); id_mdu_start = ($urandom_range(0, 4) == 0);
      ex_wreg = 5'($urandom_range(0, 3)); ex_we = 1'($urandom);
      ex_memread = ($urandom_range(0, 2) == 0);
      mem_wreg = 5'($urandom_range(0, 3)); mem_memread = ($urandom_range(0, 2) == 0);
      #1;
      obs = {PC_shouldstall, ifid_stall, ifid_flush, idex_flush, mdu_busy, mdu_go};
      checks++;
      if (obs !== exp_outs()) begin
        errors++; $display("FAIL random_outs i=%0d got=%b want=%b", i, obs, exp_outs());
      end
      checks++;
      if (stall_count !== m_cnt) begin
        errors++; $display("FAIL random_count i=%0d got=%0d want=%0d", i, stall_count, m_cnt);
      end
      tick();
    end
    rst = 0;
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_branch_after_load();
    test_mdu();
    test_back_to_back();
    test_reset_mid_op();
    test_ce_freeze();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
